// File: rtl/mod_arbiter.sv
// Round-robin arbiter that shares one repeated-subtraction engine among NREQ requesters.
// Each job returns val rounded down to a multiple of div, plus the remainder.
module mod_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 5
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*DATA_W-1:0]  i_req_val,
    input  logic [NREQ*DIV_W-1:0]   i_req_div,
    output logic [NREQ-1:0]         o_grant,
    output logic [NREQ-1:0]         o_done,
    output logic [DATA_W-1:0]       o_result,
    output logic [DATA_W-1:0]       o_remainder,
    output logic                    o_err_div0,
    output logic                    o_busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [NREQ-1:0]     r_sel;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_done;
    logic [DATA_W-1:0]   r_val;
    logic [DIV_W-1:0]    r_div;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_remainder;
    logic                r_err;
    logic                r_busy;

    logic                w_found;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_cand;
    logic [IDX_W-1:0]    w_ptr_next;
    int unsigned         w_j;
    logic [NREQ-1:0]     w_onehot;
    logic [DATA_W-1:0]   w_val;
    logic [DIV_W-1:0]    w_div;
    logic [DATA_W-1:0]   w_div_ext;

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        w_j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_j = 32'(r_ptr) + k;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            w_cand = IDX_W'(w_j);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_val    = '0;
        w_div    = '0;
        for (int unsigned s = 0; s < NREQ; s++) begin
            if (IDX_W'(s) == w_idx) begin
                w_onehot[s] = 1'b1;
                w_val       = i_req_val[s*DATA_W +: DATA_W];
                w_div       = i_req_div[s*DIV_W +: DIV_W];
            end
        end
    end

    assign w_ptr_next = (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + IDX_W'(1);
    assign w_div_ext  = DATA_W'(r_div);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_val       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_result    <= '0;
            r_remainder <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_busy <= 1'b0;
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_sel   <= w_onehot;
                        r_val   <= w_val;
                        r_div   <= w_div;
                        r_rem   <= w_val;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b1;
                        r_state <= StCalc;
                    end
                end
                StCalc: begin
                    // busy is left untouched so it stays high through the done cycle
                    if (r_div == '0) begin
                        r_result    <= r_val;
                        r_remainder <= '0;
                        r_done      <= r_sel;
                        r_err       <= 1'b1;
                        r_state     <= StIdle;
                    end else if (r_rem >= w_div_ext) begin
                        r_rem <= r_rem - w_div_ext;
                    end else begin
                        r_result    <= r_val - r_rem;
                        r_remainder <= r_rem;
                        r_done      <= r_sel;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_remainder = r_remainder;
    assign o_err_div0  = r_err;
    assign o_busy      = r_busy;

endmodule
